// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}; the LUT holds active-high patterns.
package seg_scan_driver_pkg;

  localparam int unsigned SCAN_DIV_DEF = 250000;
  localparam int unsigned CNT_W        = $clog2(SCAN_DIV_DEF);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } slot_phase_e;

  // One complete display image: per-digit blank mask plus four hex codes.
  typedef struct packed {
    logic [3:0]      blank;
    logic [3:0][3:0] digits;
  } frame_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex code to active-low 7-segment pattern; purely combinational.
module seg_hex_decoder
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = ~SEG_LUT[code_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed, double-buffered driver for a 4-digit common-anode display.
// Each slot opens with a blanking gap; new digits apply only at frame boundaries.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  frame_t           shadow_q, shadow_d;
  frame_t           active_q, active_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_wrap;
  logic             frame_end;
  slot_phase_e      phase;
  logic [6:0]       dec_seg_n;

  seg_hex_decoder u_dec (
    .code_i  (active_q.digits[digit_idx_q]),
    .seg_n_o (dec_seg_n)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    slot_wrap    = (slot_cnt_q == SLOT_LAST);
    frame_end    = slot_wrap && (digit_idx_q == 2'd3);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    digit_idx_d  = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    frame_done_d = frame_end;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;

    // The boundary transfer reads the old shadow; a coincident load stays pending.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = '{blank: blank_in, digits: digits_in};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    phase = (slot_cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (phase == PH_SHOW && !active_q.blank[digit_idx_q]) begin
      an_d  = ~(4'b0001 << digit_idx_q);
      seg_d = dec_seg_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: shadow/active are reset too, since the display must come up showing 0000 with nothing stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
// A running scoreboard compares every cycle against a positional model; scenario tasks add literal checks.
module tb_seg_scan_driver;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  logic [6:0] ref_lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: k counts edges since reset release; the image shown after
  // the most recent frame boundary is whatever was loaded strictly before it.
  typedef struct {
    int         e;
    logic [19:0] d;
  } load_t;

  load_t load_log[$];
  int    k = 0;

  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      load_log.delete();
    end else begin
      k = k + 1;
      if (load) load_log.push_back('{k, {blank_in, digits_in}});
    end
  end

  function automatic logic [19:0] frame_content(input int kk);
    int b;
    logic [19:0] c;
    c = '0;
    b = ((kk - 1) / FRAME) * FRAME;
    foreach (load_log[i])
      if (b >= FRAME && load_log[i].e < b) c = load_log[i].d;
    return c;
  endfunction

  task automatic model(input int kk, output logic [3:0] e_an, output logic [6:0] e_seg,
                       output logic e_fd);
    int p, slot, d;
    logic [19:0] c;
    logic [3:0]  code;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_fd  = 1'b0;
    if (kk > 0) begin
      p     = kk - 1;
      slot  = p % SD;
      d     = (p / SD) % 4;
      c     = frame_content(kk);
      code  = c[4*d +: 4];
      e_fd  = (kk % FRAME) == 0;
      if (slot >= BC && !c[16+d]) begin
        e_an  = 4'hF & ~(4'd1 << d);
        e_seg = ~ref_lut[code];
      end
    end
  endtask

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    if (mon_en) begin
      model(k, e_an, e_seg, e_fd);
      checks++;
      if ({an, seg, frame_done} !== {e_an, e_seg, e_fd}) begin
        errors++;
        $display("FAIL model k=%0d: an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 k, an, seg, frame_done, e_an, e_seg, e_fd);
      end
    end
  end

  // Anti-ghosting: an is F or one-hot-low; while a digit is lit, nothing changes.
  logic [3:0] prev_an = 4'hF;
  logic [6:0] prev_seg = 7'h7F;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
        errors++;
        $display("FAIL an_onehot: an=%h, expected F or one-hot-low", an);
      end
      if (prev_an != 4'hF && an != 4'hF) begin
        checks++;
        if (seg !== prev_seg || an !== prev_an) begin
          errors++;
          $display("FAIL ghost: an %h->%h seg %h->%h while lit", prev_an, an, prev_seg, seg);
        end
      end
      prev_an  = an;
      prev_seg = seg;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] b);
    digits_in = d;
    blank_in  = b;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_done=%b after %0d cycles, expected 1", tag, frame_done, n);
    end
  endtask

  task automatic align_to(input int phase, input string tag);
    int n = 0;
    while ((k % FRAME) != phase && n < 2 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if ((k % FRAME) != phase) begin
      errors++;
      $display("FAIL %s: frame phase=%0d, expected %0d", tag, k % FRAME, phase);
    end
  endtask

  task automatic test_reset();
    logic [3:0] xa;
    logic [6:0] xs;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1'b1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: an=%h seg=%h fd=%b, expected F 7F 0", an, seg, frame_done);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      xa = (i <= 2 || i == 9) ? 4'hF : 4'hE;
      xs = (i <= 2 || i == 9) ? 7'h7F : 7'h40;
      checks++;
      if (an !== xa || seg !== xs) begin
        errors++;
        $display("FAIL reset_release cycle %0d: an=%h seg=%h, expected an=%h seg=%h",
                 i, an, seg, xa, xs);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int cnt [4] = '{0, 0, 0, 0};
    int n = 0;
    tick();
    tick();
    pulse_load(16'h1234, 4'h0);
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      if (an !== 4'hF) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("FAIL load_hold: seg=%h with an=%h, expected 40 before boundary", seg, an);
        end
      end
      tick();
      n++;
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (an === an_tab[j]) begin
          cnt[j]++;
          checks++;
          if (seg !== seg_tab[j]) begin
            errors++;
            $display("FAIL load_show: an=%h seg=%h, expected seg=%h", an, seg, seg_tab[j]);
          end
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (cnt[j] != SD - BC) begin
        errors++;
        $display("FAIL load_slot_len: an=%h lit %0d cycles, expected %0d", an_tab[j], cnt[j], SD - BC);
      end
    end
  endtask

  task automatic test_blank_mask();
    int lit = 0;
    tick();
    pulse_load(16'h8888, 4'b1010);
    wait_fd("blank_boundary");
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (an !== 4'hF) begin
        lit++;
        checks++;
        if (!(an inside {4'hE, 4'hB}) || seg !== 7'h00) begin
          errors++;
          $display("FAIL blank_mask: an=%h seg=%h, expected an E/B with seg 00", an, seg);
        end
      end
    end
    checks++;
    if (lit != 2 * (SD - BC)) begin
      errors++;
      $display("FAIL blank_lit_count: %0d lit cycles, expected %0d", lit, 2 * (SD - BC));
    end
  endtask

  task automatic frame_expect(input logic [6:0] xs, input string tag);
    int lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (an !== 4'hF) begin
        lit++;
        checks++;
        if (seg !== xs) begin
          errors++;
          $display("FAIL %s: an=%h seg=%h, expected seg=%h", tag, an, seg, xs);
        end
      end
    end
    checks++;
    if (lit == 0) begin
      errors++;
      $display("FAIL %s_lit: no digit lit in frame, expected some", tag);
    end
  endtask

  task automatic test_collision();
    align_to(FRAME - 1, "coll_align_a");
    pulse_load(16'h5555, 4'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge_a: fd=%b, expected 1 on boundary", frame_done);
    end
    frame_expect(7'h00, "coll_old_a");
    align_to(FRAME - 1, "coll_align_b");
    pulse_load(16'h6666, 4'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge_b: fd=%b, expected 1 on boundary", frame_done);
    end
    frame_expect(7'h12, "coll_old_b");
    frame_expect(7'h02, "coll_new_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      digits_in = 16'($urandom);
      blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load      = ($urandom_range(0, 9) == 0);
      reset     = (i == 200 || i == 201);
      tick();
    end
    load  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_period();
    int n;
    wait_fd("period_sync");
    for (int p = 0; p < 3; p++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL period_width: fd=%b one cycle after pulse, expected 0", frame_done);
      end
      n = 1;
      while (frame_done !== 1'b1 && n < 2 * FRAME) begin
        tick();
        n++;
      end
      checks++;
      if (n != FRAME) begin
        errors++;
        $display("FAIL period_len: %0d cycles between pulses, expected %0d", n, FRAME);
      end
    end
    align_to(2 * SD + 4, "period_mid_digit2");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL period_after_reset: %0d cycles to frame_done, expected %0d", n, FRAME);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_blank_mask();
    test_collision();
    test_random();
    test_period();
    tick();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
